// File: rtl/mem_pkg.sv
// Shared widths and word type for the memory stage of the calculator datapath.
package mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : mem_pkg

// File: rtl/mem_data_ram.sv
// Word-addressed data RAM: async active-low clear, synchronous write, asynchronous read.
module data_ram
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] store [DEPTH];

  // Clearing every word on reset means no location is ever uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (we) begin
      store[addr] <= wd;
    end
  end

  assign rd = store[addr];

endmodule : data_ram

// File: rtl/mem.sv
// Memory stage: data RAM addressed by the ALU result, plus the MemtoReg result mux.
module mem
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WD,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  output logic [DATA_W-1:0] Result
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd;

  // Word index straight from the low bits: no byte shift, upper bits wrap.
  assign addr = ALUResult[ADDR_W-1:0];

  data_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_data_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (MemWrite),
    .addr (addr),
    .wd   (WD),
    .rd   (rd)
  );

  assign Result = MemtoReg ? rd : ALUResult;

endmodule : mem

// File: tb/tb_mem.sv
// Directed and randomised checks of the memory stage against a reference word array.
module tb_mem;
  import mem_pkg::*;

  localparam int W     = DEF_DATA_W;
  localparam int DEPTH = 2 ** DEF_ADDR_W;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] alu_result;
  logic [W-1:0] wd;
  logic         mem_write;
  logic         mem_to_reg;
  logic [W-1:0] result;

  logic [W-1:0] exp_q[$];
  word_t        ref_mem [DEPTH];
  int           checks;
  int           errors;

  mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ALUResult(alu_result),
    .WD       (wd),
    .MemWrite (mem_write),
    .MemtoReg (mem_to_reg),
    .Result   (result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic m2r, input logic we,
                       input logic [W-1:0] d);
    alu_result = a;
    mem_to_reg = m2r;
    mem_write  = we;
    wd         = d;
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d);
    drive(a, 1'b1, 1'b1, d);
    tick();
    ref_mem[a[DEF_ADDR_W-1:0]] = d;
    mem_write = 1'b0;
    #1;
  endtask

  // Scoreboard
  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [W-1:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0d but scoreboard queue empty", tag, result);
    end else begin
      exp_v = exp_q.pop_front();
      assert (result === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, result, exp_v);
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rdat;
    checks = 0;
    errors = 0;
    ref_clear();

    // Reset, then reads of cleared words
    rst_n = 1'b0;
    drive(32'd12, 1'b1, 1'b0, '0);
    #10;
    expect_val(32'd0); check("in_reset_rd12");
    #3 rst_n = 1'b1;
    drive(32'd12, 1'b1, 1'b0, '0);
    expect_val(32'd0); check("reset_rd12");
    drive(32'd13, 1'b1, 1'b0, '0);
    expect_val(32'd0); check("reset_rd13");
    drive(32'd77, 1'b0, 1'b0, '0);
    expect_val(32'd77); check("reset_alu_pass");

    // Store/load, old word visible before the committing edge
    tick();
    drive(32'd12, 1'b1, 1'b1, 32'd989);
    expect_val(32'd0); check("pre_edge_old");
    tick();
    ref_mem[12] = 32'd989;
    expect_val(32'd989); check("store_load_989");
    mem_write = 1'b0;

    // Distinct consecutive words
    do_write(32'd12, 32'd0);
    do_write(32'd13, 32'd4554);
    drive(32'd12, 1'b1, 1'b0, '0);
    expect_val(32'd0); check("word12_zero");
    drive(32'd13, 1'b1, 1'b0, '0);
    expect_val(32'd4554); check("word13_4554");

    // Mux bypass while a store is committed
    drive(32'd12, 1'b0, 1'b1, 32'd4554);
    expect_val(32'd12); check("bypass_pre");
    tick();
    ref_mem[12] = 32'd4554;
    expect_val(32'd12); check("bypass_post");
    drive(32'd12, 1'b1, 1'b0, '0);
    expect_val(32'd4554); check("bypass_stored");

    // Write enable low over several edges
    drive(32'd13, 1'b1, 1'b0, 32'hDEAD_BEEF);
    tick(); tick(); tick();
    expect_val(32'd4554); check("we_low_hold");

    // Address aliasing / upper bits ignored
    do_write(32'd14, 32'h1234_5678);
    drive(32'd76, 1'b1, 1'b0, '0);
    expect_val(32'd4554); check("alias_76");
    drive(32'hFFFF_FFCE, 1'b1, 1'b0, '0);
    expect_val(32'h1234_5678); check("alias_upper_bits");
    do_write(32'd127, 32'hA5A5_0001);
    drive(32'd63, 1'b1, 1'b0, '0);
    expect_val(32'hA5A5_0001); check("alias_wrap_63");

    // Randomised writes and reads against the reference array
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom_range(0, 255);
      rdat = $urandom();
      if ($urandom_range(0, 2) != 0) do_write(ra, rdat);
      ra = $urandom_range(0, 255);
      drive(ra, 1'b1, 1'b0, '0);
      expect_val(ref_mem[ra[DEF_ADDR_W-1:0]]);
      check("rand_rd");
    end

    // Async reset mid-cycle with a pending write
    do_write(32'd12, 32'd321);
    do_write(32'd13, 32'd654);
    drive(32'd12, 1'b1, 1'b1, 32'd999);
    expect_val(32'd321); check("pre_reset_rd12");
    #2 rst_n = 1'b0;
    #1;
    ref_clear();
    expect_val(32'd0); check("async_clear_rd12");
    tick();
    expect_val(32'd0); check("write_blocked_in_reset");
    drive(32'd13, 1'b1, 1'b0, '0);
    #2 rst_n = 1'b1;
    #1;
    expect_val(32'd0); check("after_release_rd13");

    // First write right after release
    do_write(32'd5, 32'd55);
    drive(32'd5, 1'b1, 1'b0, '0);
    expect_val(32'd55); check("first_write_after_release");
    drive(32'd69, 1'b0, 1'b0, '0);
    expect_val(32'd69); check("final_alu_pass");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover_queue: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule : tb_mem

// File: doc/mem.md
# mem

Memory stage of the ARM calculator datapath: a word-addressed data memory plus the MemtoReg result mux. It sits between the execute stage, which supplies the ALU result and store data, and write-back, which consumes `Result`. Stores commit on the clock edge. Loads and the result mux are combinational.

## Interface
Parameters:
- `DATA_W`, default 32: data and ALU width.
- `ADDR_W`, default 6: word-address bits taken from `ALUResult`.
- `DEPTH`, default 2**ADDR_W (64): number of memory words.

Ports:
- `clk`  in  1  single clock; all writes happen on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ALUResult`  in  DATA_W  memory word address for loads and stores; also the non-memory result.
- `WD`  in  DATA_W  store data.
- `MemWrite`  in  1  store enable.
- `MemtoReg`  in  1  result select: 1 = memory read data, 0 = `ALUResult`.
- `Result`  out  DATA_W  value passed to write-back.

## Operation
- Addressing: the address is the word index `ALUResult[ADDR_W-1:0]`. There is no byte-to-word shift, so consecutive values (12, 13) are distinct words. Upper bits are ignored and addresses wrap modulo DEPTH.
- Read: `RD = mem[addr]`, combinational, always active. It does not depend on `MemWrite`.
- Write: at a rising `clk` edge with `rst_n`=1 and `MemWrite`=1, `mem[addr]` is set to `WD`. With `MemWrite`=0 the memory is unchanged.
- Result mux: `Result = MemtoReg ? RD : ALUResult`, purely combinational.
- Reset: while `rst_n`=0, every memory word is cleared to 0 and writes are blocked. Reset acts immediately, without waiting for a clock edge.
- Uninitialised behaviour does not exist: after reset every location reads 0.

## Timing
- `Result` has zero-cycle latency from `ALUResult`, `MemtoReg` and the memory contents.
- Store latency is one edge. Written data is visible on `RD` and `Result` immediately after the rising edge that commits it.
- Read and write to the same address in the same cycle: before the edge `Result` shows the old word; after the edge it shows the new word. There is no write-through bypass.
- Reset value of outputs:
  - `Result` = 0 when `MemtoReg`=1.
  - `Result` = `ALUResult` when `MemtoReg`=0.
- Reset asserted mid-cycle while `MemWrite`=1: the pending write is discarded and all words are cleared.
- Reset released: the first write can occur at the next rising edge with `rst_n`=1.
- Inputs must be stable around the rising edge; changes are sampled only at the edge.

## Structure
- Shared package `mem_pkg`: `DATA_W` and `ADDR_W` defaults, and the word typedef `word_t` (DATA_W bits).
- One sub-module, `data_ram`:
  - DEPTH×DATA_W storage with async active-low clear, synchronous write port and asynchronous read port.
  - `mem` instantiates `data_ram` and adds the address slice and the MemtoReg mux.

## Test plan
- Reset then read: pulse `rst_n` low, then set `ALUResult`=12, `MemtoReg`=1, `MemWrite`=0 -> `Result`=0. Repeat for address 13 -> 0.
- Store/load: `ALUResult`=12, `WD`=989, `MemWrite`=1, then one rising edge -> with `MemtoReg`=1, `Result`=989 after the edge.
- Distinct words:
  - Store 0 to word 12, then store 4554 to word 13.
  - Read word 12 -> 0. Read word 13 -> 4554.
- Mux bypass: `ALUResult`=12, `MemtoReg`=0, `MemWrite`=1, `WD`=4554 -> `Result`=12 before and after the edge. Word 12 then reads 4554 with `MemtoReg`=1.
- Write-enable low: `MemWrite`=0, `WD`=0xDEADBEEF, address 13 over several edges -> word 13 still reads 4554.
- Async reset mid-operation: after writing words 12 and 13, drop `rst_n` between edges -> `Result` (with `MemtoReg`=1) goes to 0 immediately. An edge with `MemWrite`=1 during reset writes nothing. Aliased address 12+64=76 reads word 12.
